// File: rtl/audio_adc_deserializer_pkg.sv
// Shared types and defaults for the codec ADC receive path.
`timescale 1ns/1ps
package audio_pkg;

    localparam int AUDIO_DW          = 24;
    localparam int AUDIO_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_L,
        WAIT_R,
        SHIFT_R,
        WAIT_L
    } adc_state_t;

    typedef struct packed {
        logic [AUDIO_DW-1:0] l;
        logic [AUDIO_DW-1:0] r;
    } audio_pair_t;

endpackage

// File: rtl/audio_adc_deserializer_if.sv
// Valid/ready sample-pair bus from the ADC deserializer to its consumer.
`timescale 1ns/1ps
interface audio_adc_deserializer_if #(
    parameter int DW = audio_pkg::AUDIO_DW
);
    import audio_pkg::*;

    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output left_out,
        output right_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  left_out,
        input  right_out,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/audio_adc_deserializer_sync_edge.sv
// Multi-flop synchronizer for one asynchronous codec line, with a registered
// rising-edge pulse taken from the synchronized value.
`timescale 1ns/1ps
module sync_edge
    import audio_pkg::*;
#(
    parameter int STAGES = AUDIO_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                chain_q[i] <= chain_q[i-1];
            end
            chain_q[0] <= d_i;
            prev_q     <= chain_q[STAGES-1];
            rise_q     <= chain_q[STAGES-1] & ~prev_q;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = rise_q;

endmodule

// File: rtl/audio_adc_deserializer.sv
// Left-justified codec ADC deserializer: frames serial data by LRCK into
// left/right words and hands completed pairs to a one-entry output buffer.
//
// state   | meaning
// IDLE    | waiting for LRCK 0->1 to start a left word
// SHIFT_L | shifting left-channel bits, MSB first
// WAIT_R  | left word full, ignoring surplus slot bits until LRCK 1->0
// SHIFT_R | shifting right-channel bits, MSB first
// WAIT_L  | pair complete, ignoring surplus slot bits until LRCK 0->1
`timescale 1ns/1ps
module audio_adc_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DW,
    parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     bclk_in,
    input  logic                     lrck_in,
    input  logic                     adcdat_in,
    audio_adc_deserializer_if.master aud,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    localparam int             DW       = DATA_WIDTH;
    localparam int             CW       = $clog2(DW + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DW);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

    logic bclk_rise, lrck_s, dat_s;
    logic bclk_sync_unused, lrck_rise_unused, dat_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk_i (CLOCK_50), .rst_ni(resetn), .d_i(bclk_in),
        .sync_o(bclk_sync_unused), .rise_o(bclk_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk_i (CLOCK_50), .rst_ni(resetn), .d_i(lrck_in),
        .sync_o(lrck_s), .rise_o(lrck_rise_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .clk_i (CLOCK_50), .rst_ni(resetn), .d_i(adcdat_in),
        .sync_o(dat_s), .rise_o(dat_rise_unused)
    );

    adc_state_t    state_q, state_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] left_word_q, left_word_d;
    logic          lrck_prev_q;
    logic          pair_done;
    logic [DW-1:0] pair_r;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] left_q, left_d;
    logic [DW-1:0] right_q, right_d;
    logic          overrun_q, overrun_d;

    logic          lrck_up, lrck_dn, accept;
    logic [DW-1:0] shifted, first_bit;

    // A short word keeps its received bits MSB-aligned; unreceived LSBs read as 0.
    function automatic logic [DW-1:0] zero_fill(input logic [DW-1:0] sh,
                                                input logic [CW-1:0] k);
        return sh << (CNT_FULL - k);
    endfunction

    assign lrck_up   = lrck_s & ~lrck_prev_q;
    assign lrck_dn   = ~lrck_s & lrck_prev_q;
    assign shifted   = {shreg_q[DW-2:0], dat_s};
    assign first_bit = {{(DW-1){1'b0}}, dat_s};
    assign accept    = out_valid_q & aud.out_ready;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            left_word_q <= '0;
            lrck_prev_q <= 1'b0;
            out_valid_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            left_word_q <= left_word_d;
            if (bclk_rise) begin
                lrck_prev_q <= lrck_s;
            end
            out_valid_q <= out_valid_d;
            left_q      <= left_d;
            right_q     <= right_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        left_word_d = left_word_q;
        pair_done   = 1'b0;
        pair_r      = '0;
        if (!enable) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            shreg_d  = '0;
        end else if (bclk_rise) begin
            unique case (state_q)
                IDLE, WAIT_L: begin
                    if (lrck_up) begin
                        shreg_d  = first_bit;
                        bitcnt_d = CW'(1);
                        state_d  = SHIFT_L;
                    end
                end
                SHIFT_L: begin
                    if (lrck_dn) begin
                        left_word_d = zero_fill(shreg_q, bitcnt_q);
                        shreg_d     = first_bit;
                        bitcnt_d    = CW'(1);
                        state_d     = SHIFT_R;
                    end else if (bitcnt_q < CNT_FULL) begin
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CNT_LAST) begin
                            left_word_d = shifted;
                            state_d     = WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (lrck_dn) begin
                        shreg_d  = first_bit;
                        bitcnt_d = CW'(1);
                        state_d  = SHIFT_R;
                    end
                end
                SHIFT_R: begin
                    if (lrck_up) begin
                        pair_done = 1'b1;
                        pair_r    = zero_fill(shreg_q, bitcnt_q);
                        shreg_d   = first_bit;
                        bitcnt_d  = CW'(1);
                        state_d   = SHIFT_L;
                    end else if (bitcnt_q < CNT_FULL) begin
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CNT_LAST) begin
                            pair_done = 1'b1;
                            pair_r    = shifted;
                            state_d   = WAIT_L;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Clear is applied first so a same-cycle drop leaves overrun set.
    always_comb begin
        out_valid_d = out_valid_q;
        left_d      = left_q;
        right_d     = right_q;
        overrun_d   = overrun_q;
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (pair_done) begin
            if (!out_valid_q || accept) begin
                left_d      = left_word_q;
                right_d     = pair_r;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    assign aud.left_out  = left_q;
    assign aud.right_out = right_q;
    assign aud.out_valid = out_valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Self-checking bench for audio_adc_deserializer: drives a left-justified codec
// stream and checks received pairs against a word-level reference.
`timescale 1ns/1ps
module tb_audio_adc_deserializer;
    import audio_pkg::*;

    localparam int DW   = AUDIO_DW;
    localparam int HALF = 163;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic bclk = 1'b0;
    logic lrck = 1'b0;
    logic adcdat = 1'b0;
    logic clear_ov = 1'b0;
    logic overrun;

    int passed = 0;
    int total  = 0;

    logic [47:0] got_q[$];
    logic [47:0] exp_q[$];

    audio_adc_deserializer_if #(.DW(DW)) aud();

    always #10 clk = ~clk;

    audio_adc_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .CLOCK_50     (clk),
        .resetn       (rst_n),
        .enable       (enable),
        .bclk_in      (bclk),
        .lrck_in      (lrck),
        .adcdat_in    (adcdat),
        .aud          (aud),
        .overrun      (overrun),
        .clear_overrun(clear_ov)
    );

    always @(negedge clk) begin
        if (rst_n && aud.out_valid && aud.out_ready)
            got_q.push_back({aud.left_out, aud.right_out});
    end

    // Reference: the first min(n, DW) transmitted bits, MSB-aligned, rest zero.
    function automatic logic [23:0] word_of(input logic [31:0] slot, input int n);
        logic [23:0] w;
        logic [23:0] ones;
        w    = slot[31:8];
        ones = '1;
        if (n < DW) w = w & ~(ones >> n);
        return w;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic lr, input logic b);
        bclk = 1'b0; lrck = lr; adcdat = b;
        #HALF;
        bclk = 1'b1;
        #HALF;
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] slot, input int n);
        for (int i = 0; i < n; i++) send_bit(lr, slot[31-i]);
    endtask

    task automatic send_frame(input logic [31:0] lv, input logic [31:0] rv, input int n);
        send_slot(1'b1, lv, n);
        send_slot(1'b0, rv, n);
    endtask

    task automatic resync();
        enable = 1'b0;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        wait_clk(2);
        enable = 1'b1;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_ov = 1'b1;
        @(posedge clk); #1 clear_ov = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (aud.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", aud.out_valid); else passed++;
        total++; if (aud.left_out !== 24'h0) $display("FAIL reset_left: got %h expected 000000", aud.left_out); else passed++;
        total++; if (aud.right_out !== 24'h0) $display("FAIL reset_right: got %h expected 000000", aud.right_out); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        #3 rst_n = 1'b1;
        enable = 1'b1;
        aud.out_ready = 1'b1;
        wait_clk(2);
    endtask

    task automatic test_basic();
        logic [31:0] lv, rv;
        logic [47:0] g;
        got_q.delete();
        lv = {24'hA55A01, 8'($urandom)};
        rv = {24'h80_00FF, 8'($urandom)};
        resync();
        send_frame(lv, rv, 32);
        wait_clk(12);
        total++; if (got_q.size() != 1) $display("FAIL basic_count: got %0d pairs expected 1", got_q.size()); else passed++;
        g = (got_q.size() > 0) ? got_q[0] : 'x;
        total++; if (g !== {24'hA55A01, 24'h8000FF}) $display("FAIL basic_pair: got %h expected a55a018000ff", g); else passed++;
        total++; if (aud.out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b expected 0", aud.out_valid); else passed++;
    endtask

    task automatic test_random();
        int lens[6];
        logic [31:0] lv, rv;
        int n;
        lens = '{12, 16, 20, 24, 28, 32};
        got_q.delete(); exp_q.delete();
        resync();
        for (int f = 0; f < 6; f++) begin
            n  = lens[$urandom_range(0, 5)];
            lv = $urandom; rv = $urandom;
            exp_q.push_back({word_of(lv, n), word_of(rv, n)});
            send_frame(lv, rv, n);
        end
        send_bit(1'b1, 1'($urandom));
        wait_clk(12);
        total++; if (got_q.size() != exp_q.size()) $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL random_pair%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 48'h0, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_overrun();
        logic [31:0] l1, r1;
        logic [47:0] first;
        logic seen;
        got_q.delete();
        aud.out_ready = 1'b0;
        l1 = $urandom; r1 = $urandom;
        first = {l1[31:8], r1[31:8]};
        resync();
        send_frame(l1, r1, 32);
        for (int f = 0; f < 2; f++) send_frame($urandom, $urandom, 32);
        wait_clk(12);
        total++; if (aud.out_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", aud.out_valid); else passed++;
        total++; if ({aud.left_out, aud.right_out} !== first) $display("FAIL ovr_held: got %h expected %h", {aud.left_out, aud.right_out}, first); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else passed++;
        pulse_clear();
        @(negedge clk);
        total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else passed++;
        total++; if (aud.out_valid !== 1'b1) $display("FAIL ovr_clear_valid: got %b expected 1", aud.out_valid); else passed++;
        // Hold clear across the next drop; overrun can only rise if set beats clear.
        seen = 1'b0;
        @(posedge clk); #1 clear_ov = 1'b1;
        fork
            send_frame($urandom, $urandom, 32);
            begin
                for (int c = 0; c < 1500 && !seen; c++) begin
                    @(negedge clk);
                    if (overrun === 1'b1) begin
                        seen = 1'b1;
                        clear_ov = 1'b0;
                    end
                end
                clear_ov = 1'b0;
            end
        join
        total++; if (seen !== 1'b1) $display("FAIL ovr_set_wins: got %b expected 1 within budget", seen); else passed++;
        wait_clk(12);
        total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun); else passed++;
        total++; if ({aud.left_out, aud.right_out} !== first) $display("FAIL ovr_held2: got %h expected %h", {aud.left_out, aud.right_out}, first); else passed++;
        aud.out_ready = 1'b1;
        wait_clk(3);
        total++; if (got_q.size() != 1 || got_q[0] !== first) $display("FAIL ovr_accept: got %0d pairs first %h expected 1 pair %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 48'h0, first); else passed++;
        total++; if (aud.out_valid !== 1'b0) $display("FAIL ovr_valid_drop: got %b expected 0", aud.out_valid); else passed++;
        pulse_clear();
    endtask

    task automatic test_enable();
        logic [31:0] la, ra, lb, lc, rc;
        logic [47:0] a, c;
        got_q.delete();
        aud.out_ready = 1'b0;
        la = $urandom; ra = $urandom; lb = $urandom; lc = $urandom; rc = $urandom;
        a = {la[31:8], ra[31:8]};
        c = {lc[31:8], rc[31:8]};
        resync();
        send_frame(la, ra, 32);
        wait_clk(12);
        send_slot(1'b1, lb, 10);
        enable = 1'b0;
        wait_clk(4);
        total++; if (aud.out_valid !== 1'b1) $display("FAIL en_valid_off: got %b expected 1", aud.out_valid); else passed++;
        total++; if ({aud.left_out, aud.right_out} !== a) $display("FAIL en_held_off: got %h expected %h", {aud.left_out, aud.right_out}, a); else passed++;
        enable = 1'b1;
        for (int i = 10; i < 32; i++) send_bit(1'b1, lb[31-i]);
        send_slot(1'b0, $urandom, 32);
        wait_clk(12);
        total++; if (aud.out_valid !== 1'b1) $display("FAIL en_valid_after: got %b expected 1", aud.out_valid); else passed++;
        total++; if ({aud.left_out, aud.right_out} !== a) $display("FAIL en_held_after: got %h expected %h", {aud.left_out, aud.right_out}, a); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL en_no_overrun: got %b expected 0", overrun); else passed++;
        aud.out_ready = 1'b1;
        wait_clk(3);
        send_frame(lc, rc, 32);
        wait_clk(12);
        total++; if (got_q.size() != 2) $display("FAIL en_count: got %0d expected 2", got_q.size()); else passed++;
        total++; if (got_q.size() != 2 || got_q[0] !== a || got_q[1] !== c) $display("FAIL en_pairs: got %h %h expected %h %h", (got_q.size() > 0) ? got_q[0] : 48'h0, (got_q.size() > 1) ? got_q[1] : 48'h0, a, c); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] la, ra, lb, rb, lc, rc;
        logic [47:0] c;
        got_q.delete();
        aud.out_ready = 1'b0;
        la = $urandom; ra = $urandom; lb = $urandom; rb = $urandom; lc = $urandom; rc = $urandom;
        c = {lc[31:8], rc[31:8]};
        resync();
        send_frame(la, ra, 32);
        wait_clk(12);
        send_slot(1'b1, lb, 32);
        send_slot(1'b0, rb, 5);
        total++; if (aud.out_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b expected 1", aud.out_valid); else passed++;
        @(posedge clk);
        #5 rst_n = 1'b0;
        #2;
        total++; if (aud.out_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", aud.out_valid); else passed++;
        total++; if ({aud.left_out, aud.right_out} !== 48'h0) $display("FAIL ar_data: got %h expected 0", {aud.left_out, aud.right_out}); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL ar_overrun: got %b expected 0", overrun); else passed++;
        wait_clk(3);
        rst_n = 1'b1;
        aud.out_ready = 1'b1;
        // Resume mid right slot: nothing may come out before the next LRCK rise.
        for (int i = 5; i < 32; i++) send_bit(1'b0, rb[31-i]);
        wait_clk(12);
        total++; if (got_q.size() != 0) $display("FAIL mid_no_output: got %0d pairs expected 0", got_q.size()); else passed++;
        send_frame(lc, rc, 32);
        wait_clk(12);
        total++; if (got_q.size() != 1 || got_q[0] !== c) $display("FAIL mid_first_pair: got %0d pairs first %h expected %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 48'h0, c); else passed++;
    endtask

    initial begin
        aud.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_overrun();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
